vga_box_compositor: RTL and testbench

- Parametrised successor to the fixed two-box/one-sprite overlay path in the VGA controller.
- Draws NUM_BOXES solid rectangles over a background colour stream. Each box has its own size, colour, enable and blink mode.
- Box geometry is latched only at the frame boundary, so a box never tears mid-frame. Edges are clamped at the screen limits instead of wrapping.
- Reports per-pixel hits and a per-frame collision vector (box 0 against every other box) to game logic.
- Sits between the timing generator/background RAM and the VGA_R/G/B pins.

---
 rtl/vga_box_compositor_if.sv | 34 +++
 rtl/vga_box_compositor.sv | 94 +++++++++
 tb/tb_vga_box_compositor.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/vga_box_compositor_if.sv
// Pixel-stream bundle between the timing generator, game logic and the box compositor.
// Carries the per-pixel stream, the packed per-box controls and the composited results.
interface vga_box_compositor_if #(
  parameter int NUM_BOXES = 4,
  parameter int HALF_W    = 6,
  parameter int FRAME_W   = 8
);
  logic                        screenEnd;
  logic                        active;
  logic [9:0]                  x;
  logic [8:0]                  y;
  logic [11:0]                 bg_color;
  logic [NUM_BOXES*10-1:0]     box_cx;
  logic [NUM_BOXES*9-1:0]      box_cy;
  logic [NUM_BOXES*HALF_W-1:0] box_half;
  logic [NUM_BOXES*12-1:0]     box_color;
  logic [NUM_BOXES-1:0]        box_en;
  logic [NUM_BOXES-1:0]        box_blink;
  logic [11:0]                 color_out;
  logic [NUM_BOXES-1:0]        hit;
  logic [NUM_BOXES-1:0]        overlap;
  logic [FRAME_W-1:0]          frame_count;

  modport master (
    output screenEnd, active, x, y, bg_color,
           box_cx, box_cy, box_half, box_color, box_en, box_blink,
    input  color_out, hit, overlap, frame_count
  );
  modport slave (
    input  screenEnd, active, x, y, bg_color,
           box_cx, box_cy, box_half, box_color, box_en, box_blink,
    output color_out, hit, overlap, frame_count
  );
endinterface

// File: rtl/vga_box_compositor.sv
// Composites NUM_BOXES solid rectangles over the background stream, one cycle of latency.
// Box geometry is captured only on screenEnd; reports per-pixel hits and box-0 collisions.
module vga_box_compositor #(
  parameter int NUM_BOXES = 4,
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int HALF_W    = 6,
  parameter int FRAME_W   = 8,
  parameter int BLINK_BIT = 4
) (
  input  logic                  clk_25mHz,
  input  logic                  reset,
  vga_box_compositor_if.slave   bus
);

  logic [NUM_BOXES-1:0] w_in;
  logic [11:0]          w_color;
  logic [11:0]          r_color;
  logic [NUM_BOXES-1:0] r_hit;
  logic [NUM_BOXES-1:0] r_overlap;
  logic [NUM_BOXES-1:0] r_acc;
  logic [FRAME_W-1:0]   r_frame;

  for (genvar i = 0; i < NUM_BOXES; i++) begin : g_box
    logic [9:0]        w_cx;
    logic [8:0]        w_cy;
    logic [HALF_W-1:0] w_half;
    logic [10:0]       w_l, w_t, w_r, w_b;
    logic [9:0]        r_left, r_right;
    logic [8:0]        r_top, r_bot;
    logic              r_vis;

    assign w_cx   = bus.box_cx[10*i +: 10];
    assign w_cy   = bus.box_cy[9*i +: 9];
    assign w_half = bus.box_half[HALF_W*i +: HALF_W];
    // 11-bit arithmetic so a negative left/top shows up in bit 10 instead of wrapping
    assign w_l = {1'b0, w_cx} - 11'(w_half);
    assign w_t = {2'b0, w_cy} - 11'(w_half);
    assign w_r = {1'b0, w_cx} + 11'(w_half);
    assign w_b = {2'b0, w_cy} + 11'(w_half);

    always_ff @(posedge clk_25mHz) begin
      if (!reset) begin
        r_left  <= '0;
        r_right <= '0;
        r_top   <= '0;
        r_bot   <= '0;
        r_vis   <= 1'b0;
      end else if (bus.screenEnd) begin
        r_left  <= w_l[10] ? '0 : w_l[9:0];
        r_right <= (w_r > 11'(WIDTH-1))  ? 10'(WIDTH-1) : w_r[9:0];
        r_top   <= w_t[10] ? '0 : w_t[8:0];
        r_bot   <= (w_b > 11'(HEIGHT-1)) ? 9'(HEIGHT-1) : w_b[8:0];
        r_vis   <= bus.box_en[i] && (!bus.box_blink[i] || !r_frame[BLINK_BIT]);
      end
    end

    assign w_in[i] = r_vis && (bus.x >= r_left) && (bus.x <= r_right)
                           && (bus.y >= r_top)  && (bus.y <= r_bot);
  end

  // Ascending scan: the highest-index box that covers the pixel wins
  always_comb begin
    w_color = bus.bg_color;
    for (int i = 0; i < NUM_BOXES; i++)
      if (w_in[i]) w_color = bus.box_color[12*i +: 12];
  end

  always_ff @(posedge clk_25mHz) begin
    if (!reset) begin
      r_color   <= '0;
      r_hit     <= '0;
      r_overlap <= '0;
      r_acc     <= '0;
      r_frame   <= '0;
    end else begin
      r_color <= bus.active ? w_color : 12'h000;
      r_hit   <= bus.active ? w_in : '0;
      if (bus.screenEnd) begin
        r_overlap <= r_acc;
        r_acc     <= '0;
        r_frame   <= r_frame + 1'b1;
      end else if (bus.active) begin
        r_acc <= r_acc | ({NUM_BOXES{w_in[0]}} & {w_in[NUM_BOXES-1:1], 1'b0});
      end
    end
  end

  assign bus.color_out   = r_color;
  assign bus.hit         = r_hit;
  assign bus.overlap     = r_overlap;
  assign bus.frame_count = r_frame;

endmodule

// File: tb/tb_vga_box_compositor.sv
// Directed bench for vga_box_compositor: table of pixel probes plus hand-written
// sequences for reset, latency, overlap, mid-frame geometry change and blinking.
module tb_vga_box_compositor;
  localparam int NB = 4;
  localparam logic [11:0] BG = 12'h123;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  vga_box_compositor_if #(.NUM_BOXES(NB), .HALF_W(6), .FRAME_W(8)) bus();

  vga_box_compositor #(.NUM_BOXES(NB), .WIDTH(640), .HEIGHT(480), .HALF_W(6),
                       .FRAME_W(8), .BLINK_BIT(4)) dut (
    .clk_25mHz(clk), .reset(rst_n), .bus(bus.slave));

  typedef struct {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [11:0] col;
    logic [3:0]  hit;
  } vec_t;

  vec_t tbl[21];
  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_box(input int i, input int cx, input int cy, input int half,
                         input logic [11:0] col, input logic en, input logic blink);
    bus.box_cx[10*i +: 10]  = 10'(cx);
    bus.box_cy[9*i +: 9]    = 9'(cy);
    bus.box_half[6*i +: 6]  = 6'(half);
    bus.box_color[12*i +: 12] = col;
    bus.box_en[i]    = en;
    bus.box_blink[i] = blink;
  endtask

  task automatic pix(input int px, input int py, input logic act);
    bus.x = 10'(px); bus.y = 9'(py); bus.active = act; bus.screenEnd = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic frame_end();
    bus.active = 1'b0; bus.screenEnd = 1'b1;
    @(posedge clk); #1;
    bus.screenEnd = 1'b0;
  endtask

  task automatic run_tbl(input int lo, input int hi, input string tag);
    for (int k = lo; k <= hi; k++) begin
      pix(int'(tbl[k].x), int'(tbl[k].y), 1'b1);
      check($sformatf("%s_col[%0d]", tag, k), 32'(bus.color_out), 32'(tbl[k].col));
      check($sformatf("%s_hit[%0d]", tag, k), 32'(bus.hit), 32'(tbl[k].hit));
    end
  endtask

  initial begin
    // box0 at (100,100) half 5
    tbl[0]  = '{95, 95, 12'hABC, 4'b0001};
    tbl[1]  = '{105,105,12'hABC, 4'b0001};
    tbl[2]  = '{94, 100,BG,      4'b0000};
    tbl[3]  = '{106,100,BG,      4'b0000};
    tbl[4]  = '{100,94, BG,      4'b0000};
    tbl[5]  = '{100,106,BG,      4'b0000};
    tbl[6]  = '{100,100,12'hABC, 4'b0001};
    // box1 red (100,100,h10), box2 green (105,100,h10)
    tbl[7]  = '{107,100,12'h0F0, 4'b0110};
    tbl[8]  = '{92, 100,12'hF00, 4'b0010};
    tbl[9]  = '{112,100,12'h0F0, 4'b0100};
    tbl[10] = '{89, 100,BG,      4'b0000};
    // clamping: box0 blue (3,100,h10), box1 yellow (635,475,h10)
    tbl[11] = '{0,   100,12'h00F, 4'b0001};
    tbl[12] = '{13,  100,12'h00F, 4'b0001};
    tbl[13] = '{14,  100,BG,      4'b0000};
    tbl[14] = '{1017,100,BG,      4'b0000};
    tbl[15] = '{625, 470,12'hFF0, 4'b0010};
    tbl[16] = '{639, 479,12'hFF0, 4'b0010};
    tbl[17] = '{624, 470,BG,      4'b0000};
    tbl[18] = '{630, 464,BG,      4'b0000};
    tbl[19] = '{630, 465,12'hFF0, 4'b0010};
    tbl[20] = '{630, 480,BG,      4'b0000};

    bus.screenEnd = 0; bus.active = 0; bus.x = 0; bus.y = 0; bus.bg_color = BG;
    bus.box_cx = '0; bus.box_cy = '0; bus.box_half = '0; bus.box_color = '0;
    bus.box_en = '0; bus.box_blink = '0;

    // reset held 3 cycles with a box already enabled
    set_box(0, 100, 100, 5, 12'hABC, 1'b1, 1'b0);
    bus.active = 1'b1; bus.x = 10'd100; bus.y = 9'd100;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_color", 32'(bus.color_out), 0);
    check("rst_hit", 32'(bus.hit), 0);
    check("rst_overlap", 32'(bus.overlap), 0);
    check("rst_frame", 32'(bus.frame_count), 0);
    rst_n = 1'b1;

    // before the first screenEnd only background is drawn
    pix(100, 100, 1'b1);
    check("pre_frame_col", 32'(bus.color_out), 32'(BG));
    check("pre_frame_hit", 32'(bus.hit), 0);
    frame_end();
    check("frame_cnt1", 32'(bus.frame_count), 1);
    run_tbl(0, 6, "box0");

    // registered output: a new input does not show before the next edge
    pix(100, 100, 1'b1);
    bus.x = 10'd0; bus.y = 9'd0; #5;
    check("latency_hold", 32'(bus.color_out), 32'(12'hABC));
    @(posedge clk); #1;
    check("latency_next", 32'(bus.color_out), 32'(BG));
    pix(100, 100, 1'b0);
    check("inactive_col", 32'(bus.color_out), 0);
    check("inactive_hit", 32'(bus.hit), 0);

    // priority
    set_box(0, 0, 0, 0, 12'h000, 1'b0, 1'b0);
    set_box(1, 100, 100, 10, 12'hF00, 1'b1, 1'b0);
    set_box(2, 105, 100, 10, 12'h0F0, 1'b1, 1'b0);
    frame_end();
    run_tbl(7, 10, "prio");

    // clamping at the screen edges
    set_box(0, 3, 100, 10, 12'h00F, 1'b1, 1'b0);
    set_box(1, 635, 475, 10, 12'hFF0, 1'b1, 1'b0);
    set_box(2, 0, 0, 0, 12'h000, 1'b0, 1'b0);
    frame_end();
    run_tbl(11, 20, "clamp");

    // overlap: boxes 0 and 2 collide in frame N, separated in N+1
    set_box(0, 100, 100, 5, 12'hABC, 1'b1, 1'b0);
    set_box(1, 0, 0, 0, 12'h000, 1'b0, 1'b0);
    set_box(2, 103, 100, 5, 12'h0F0, 1'b1, 1'b0);
    frame_end();
    check("ovl_pre", 32'(bus.overlap), 0);
    pix(102, 100, 1'b1);
    check("ovl_pix_col", 32'(bus.color_out), 32'(12'h0F0));
    check("ovl_pix_hit", 32'(bus.hit), 32'(4'b0101));
    set_box(2, 300, 100, 5, 12'h0F0, 1'b1, 1'b0);
    frame_end();
    check("ovl_N", 32'(bus.overlap), 32'(4'b0100));
    pix(102, 100, 1'b1);
    check("sep_col0", 32'(bus.color_out), 32'(12'hABC));
    pix(300, 100, 1'b1);
    check("sep_hit2", 32'(bus.hit), 32'(4'b0100));
    frame_end();
    check("ovl_N1", 32'(bus.overlap), 0);

    // geometry change mid-frame waits for screenEnd
    set_box(2, 0, 0, 0, 12'h000, 1'b0, 1'b0);
    set_box(0, 200, 100, 2, 12'h0FF, 1'b1, 1'b0);
    frame_end();
    pix(200, 100, 1'b1);
    check("mid_old_a", 32'(bus.color_out), 32'(12'h0FF));
    set_box(0, 300, 100, 2, 12'h0FF, 1'b1, 1'b0);
    pix(200, 100, 1'b1);
    check("mid_old_b", 32'(bus.color_out), 32'(12'h0FF));
    pix(300, 100, 1'b1);
    check("mid_new_early", 32'(bus.color_out), 32'(BG));
    frame_end();
    pix(300, 100, 1'b1);
    check("mid_new", 32'(bus.color_out), 32'(12'h0FF));
    pix(200, 100, 1'b1);
    check("mid_old_gone", 32'(bus.color_out), 32'(BG));

    // reset mid-frame: immediate zero, then background for the rest of the frame
    rst_n = 1'b0;
    pix(300, 100, 1'b1);
    check("mrst_col", 32'(bus.color_out), 0);
    check("mrst_frame", 32'(bus.frame_count), 0);
    rst_n = 1'b1;
    pix(300, 100, 1'b1);
    check("mrst_bg", 32'(bus.color_out), 32'(BG));
    check("mrst_hit", 32'(bus.hit), 0);

    // blinking over 64 frames starting from frame_count 0
    set_box(0, 200, 100, 2, 12'h0FF, 1'b1, 1'b1);
    for (int f = 0; f < 64; f++) begin
      logic [7:0] fc;
      fc = 8'(f);
      frame_end();
      pix(200, 100, 1'b1);
      check($sformatf("blink_f%0d", f), 32'(bus.color_out),
            fc[4] ? 32'(BG) : 32'(12'h0FF));
    end
    check("blink_frames", 32'(bus.frame_count), 64);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
